// File: rtl/rr_req_pending_tracker_pkg.sv
// Shared types and helpers for the round-robin request tracker and its arbiter consumers.
// Provides the counter width default, index-width sizing and a lowest-set-bit encoder.
package rr_req_pending_tracker_pkg;

  localparam int unsigned DEFAULT_N     = 32;
  localparam int unsigned DEFAULT_CNT_W = 4;
  localparam int unsigned MAX_N         = 256;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cntOp_e;

  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit wins, so a multi-hot vector still yields a deterministic index.
  function automatic int unsigned oneHotToIdx(input logic [MAX_N-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pending_counter.sv
// One source's saturating up/down pending counter with its sticky overflow flag.
module rr_pending_counter
  import rr_req_pending_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_gnt,
  input  logic             i_ovfClr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_isZero;
  logic             w_isMax;
  logic             w_dec;
  logic             w_drop;
  cntOp_e           w_op;

  assign w_isZero = (r_cnt == '0);
  assign w_isMax  = &r_cnt;
  assign w_dec    = i_gnt && !w_isZero;

  // A pulse coinciding with a retiring grant is a net no-op, even at saturation.
  always_comb begin
    w_op   = CNT_HOLD;
    w_drop = 1'b0;
    if (i_inc && !w_dec) begin
      if (w_isMax) w_drop = 1'b1;
      else         w_op   = CNT_INC;
    end else if (w_dec && !i_inc) begin
      w_op = CNT_DEC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (w_op)
        CNT_INC: r_cnt <= r_cnt + 1'b1;
        CNT_DEC: r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_ovfClr)    r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/rr_req_pending_tracker.sv
// Counts outstanding request pulses per source, presents a level req vector to the arbiter
// and retires one pending request per accepted grant.
module rr_req_pending_tracker
  import rr_req_pending_tracker_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N-1:0]              i_req_pulse,
  input  logic [N-1:0]              i_gnt,
  input  logic                      i_ovf_clr,
  output logic [N-1:0]              o_req,
  output logic [N*CNT_W-1:0]        o_pending_cnt,
  output logic                      o_gnt_vld,
  output logic [idxWidth(N)-1:0]    o_gnt_idx,
  output logic [N-1:0]              o_ovf,
  output logic                      o_gnt_err
);

  localparam int unsigned IDX_W = idxWidth(N);

  logic [CNT_W-1:0] w_cnt [N];
  logic [N-1:0]     w_req;
  logic [N-1:0]     w_validGnt;
  logic [MAX_N-1:0] w_validGntWide;
  logic             w_spurious;
  logic             w_multiHot;
  logic [IDX_W-1:0] w_encIdx;
  logic             r_gntVld;
  logic [IDX_W-1:0] r_gntIdx;
  logic             r_gntErr;

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    rr_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_inc    (i_req_pulse[gi]),
      .i_gnt    (i_gnt[gi]),
      .i_ovfClr (i_ovf_clr),
      .o_cnt    (w_cnt[gi]),
      .o_ovf    (o_ovf[gi])
    );
    assign w_req[gi] = |w_cnt[gi];
    assign o_pending_cnt[gi*CNT_W +: CNT_W] = w_cnt[gi];
  end

  // req comes only from counter registers, which breaks any loop through a combinational arbiter.
  assign o_req = w_req;

  assign w_validGnt     = i_gnt & w_req;
  assign w_spurious     = |(i_gnt & ~w_req);
  assign w_multiHot     = |(i_gnt & (i_gnt - N'(1)));
  assign w_validGntWide = MAX_N'(w_validGnt);
  assign w_encIdx       = IDX_W'(oneHotToIdx(w_validGntWide));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_gntVld <= 1'b0;
      r_gntIdx <= '0;
      r_gntErr <= 1'b0;
    end else begin
      r_gntVld <= |w_validGnt;
      if (|w_validGnt) r_gntIdx <= w_encIdx;
      if (i_ovf_clr)                     r_gntErr <= 1'b0;
      else if (w_spurious || w_multiHot) r_gntErr <= 1'b1;
    end
  end

  assign o_gnt_vld = r_gntVld;
  assign o_gnt_idx = r_gntIdx;
  assign o_gnt_err = r_gntErr;

endmodule

// File: tb/tb_rr_req_pending_tracker.sv
// Scoreboard bench: the driver pushes expected next-cycle state, a monitor pops and compares.
module tb_rr_req_pending_tracker;
  import rr_req_pending_tracker_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 4;
  localparam int IDX_W = $clog2(N);
  localparam int W     = N * CNT_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_pulse = '0;
  logic [N-1:0]     gnt = '0;
  logic             ovf_clr = 1'b0;
  logic [N-1:0]     o_req;
  logic [W-1:0]     o_pending_cnt;
  logic             o_gnt_vld;
  logic [IDX_W-1:0] o_gnt_idx;
  logic [N-1:0]     o_ovf;
  logic             o_gnt_err;

  always #5 clk = ~clk;

  rr_req_pending_tracker #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_pulse   (req_pulse),
    .i_gnt         (gnt),
    .i_ovf_clr     (ovf_clr),
    .o_req         (o_req),
    .o_pending_cnt (o_pending_cnt),
    .o_gnt_vld     (o_gnt_vld),
    .o_gnt_idx     (o_gnt_idx),
    .o_ovf         (o_ovf),
    .o_gnt_err     (o_gnt_err)
  );

  typedef struct {
    int               step;
    logic [W-1:0]     cnt;
    logic [N-1:0]     req;
    logic [N-1:0]     ovf;
    logic             err;
    logic             vld;
    logic [IDX_W-1:0] idx;
    int               hSrc;
    int               hCnt;
    int               hIdx;
  } exp_t;

  exp_t             expQ [$];
  int               totalChecks = 0;
  int               passChecks  = 0;
  int               stepId      = 0;
  int               arbPtr      = 0;
  logic [CNT_W-1:0] mCnt [N];
  logic [N-1:0]     mOvf = '0;
  logic             mErr = 1'b0;
  logic             mVld = 1'b0;
  logic [IDX_W-1:0] mIdx = '0;

  function automatic logic [N-1:0] oneBit(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int step, input logic [W-1:0] act,
                             input logic [W-1:0] expv);
    totalChecks++;
    if (act === expv) passChecks++;
    else $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, expv);
  endtask

  // Drives one cycle of inputs at negedge and pushes the state expected after the next posedge.
  task automatic applyStimulus(input bit rstActive, input logic [N-1:0] p, input logic [N-1:0] g,
                               input bit clr, input bit useArb, input int hSrc, input int hCnt,
                               input int hIdx);
    logic [N-1:0] gEff, oldReq, valid, newOvf;
    exp_t e;
    @(negedge clk);
    gEff = g;
    if (useArb) begin
      gEff = '0;
      for (int off = 0; off < N; off++) begin
        int j;
        j = (arbPtr + off) % N;
        if (gEff == '0 && o_req[j]) begin
          gEff = oneBit(j);
          arbPtr = (j + 1) % N;
        end
      end
    end
    rst_n = !rstActive;
    req_pulse = p;
    gnt = gEff;
    ovf_clr = clr;
    stepId++;

    if (rstActive) begin
      for (int i = 0; i < N; i++) mCnt[i] = '0;
      mOvf = '0; mErr = 1'b0; mVld = 1'b0; mIdx = '0;
    end else begin
      for (int i = 0; i < N; i++) oldReq[i] = (mCnt[i] != '0);
      valid = gEff & oldReq;
      newOvf = '0;
      for (int i = 0; i < N; i++) begin
        if (p[i] && !valid[i]) begin
          if (mCnt[i] == CMAX) newOvf[i] = 1'b1;
          else mCnt[i] = mCnt[i] + 1'b1;
        end else if (valid[i] && !p[i]) begin
          mCnt[i] = mCnt[i] - 1'b1;
        end
      end
      mErr = clr ? 1'b0 : (mErr | (|(gEff & ~oldReq)) | ($countones(gEff) > 1));
      mOvf = clr ? '0 : (mOvf | newOvf);
      mVld = |valid;
      if (mVld) begin
        for (int i = N - 1; i >= 0; i--) if (valid[i]) mIdx = IDX_W'(i);
      end
    end

    e.step = stepId;
    for (int i = 0; i < N; i++) begin
      e.cnt[i*CNT_W +: CNT_W] = mCnt[i];
      e.req[i] = (mCnt[i] != '0);
    end
    e.ovf = mOvf; e.err = mErr; e.vld = mVld; e.idx = mIdx;
    e.hSrc = hSrc; e.hCnt = hCnt; e.hIdx = hIdx;
    expQ.push_back(e);
  endtask

  task automatic idle(input int hSrc, input int hCnt);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, hSrc, hCnt, -1);
  endtask

  // Monitor: compares DUT outputs shortly after each active edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pending_cnt", e.step, o_pending_cnt, e.cnt);
        checkOutput("req", e.step, W'(o_req), W'(e.req));
        checkOutput("ovf", e.step, W'(o_ovf), W'(e.ovf));
        checkOutput("gnt_err", e.step, W'(o_gnt_err), W'(e.err));
        checkOutput("gnt_vld", e.step, W'(o_gnt_vld), W'(e.vld));
        checkOutput("gnt_idx", e.step, W'(o_gnt_idx), W'(e.idx));
        if (e.hSrc >= 0)
          checkOutput("hand_cnt", e.step, W'(o_pending_cnt[e.hSrc*CNT_W +: CNT_W]), W'(e.hCnt));
        if (e.hIdx >= 0) begin
          checkOutput("hand_vld", e.step, W'(o_gnt_vld), W'(1));
          checkOutput("hand_idx", e.step, W'(o_gnt_idx), W'(e.hIdx));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) mCnt[i] = '0;

    $display("[TB] reset with pulses asserted");
    applyStimulus(1'b1, '1, '0, 1'b0, 1'b0, 0, 0, -1);
    applyStimulus(1'b1, '1, '0, 1'b0, 1'b0, 31, 0, -1);
    idle(0, 0);

    $display("[TB] single source 5");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, oneBit(5), '0, 1'b0, 1'b0, 5, k + 1, -1);
    idle(5, 3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, oneBit(5), 1'b0, 1'b0, 5, 2 - k, 5);
    idle(5, 0);

    $display("[TB] saturation on source 0");
    for (int k = 0; k < 17; k++)
      applyStimulus(1'b0, oneBit(0), '0, 1'b0, 1'b0, 0, (k + 1 > 15) ? 15 : k + 1, -1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 0, 15, -1);

    $display("[TB] simultaneous pulse and grant on source 2");
    for (int k = 0; k < 15; k++) applyStimulus(1'b0, oneBit(2), '0, 1'b0, 1'b0, 2, k + 1, -1);
    applyStimulus(1'b0, oneBit(2), oneBit(2), 1'b0, 1'b0, 2, 15, 2);
    for (int k = 0; k < 14; k++) applyStimulus(1'b0, '0, oneBit(2), 1'b0, 1'b0, 2, 14 - k, 2);
    applyStimulus(1'b0, oneBit(2), oneBit(2), 1'b0, 1'b0, 2, 1, 2);
    applyStimulus(1'b0, '0, oneBit(2), 1'b0, 1'b0, 2, 0, 2);

    $display("[TB] protocol errors");
    applyStimulus(1'b0, '0, oneBit(7), 1'b0, 1'b0, 7, 0, -1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 7, 0, -1);
    applyStimulus(1'b0, oneBit(3) | oneBit(9), '0, 1'b0, 1'b0, 3, 1, -1);
    applyStimulus(1'b0, '0, oneBit(3) | oneBit(9), 1'b0, 1'b0, 9, 0, 3);
    idle(3, 0);

    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 0, 0, -1);
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 0, 0, -1);
    idle(0, 0);

    $display("[TB] closed loop with round-robin arbiter");
    arbPtr = 0;
    applyStimulus(1'b0, '1, '0, 1'b0, 1'b0, 31, 1, -1);
    for (int k = 0; k < N; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, k, 0, k);
    idle(31, 0);

    for (int k = 0; k < 4 && expQ.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    #3;
    checkOutput("drain", stepId, W'(expQ.size()), W'(0));
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
